// File: rtl/param_iterative_mac.sv
// Signed multiply-accumulate that builds each a*b product over DATA_W/SLICE_W
// cycles (SLICE_W bits of b per cycle), then accumulates with optional saturation.
module param_iterative_mac #(
  parameter int DATA_W  = 8,
  parameter int SLICE_W = 4,
  parameter int ACC_W   = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic signed [ACC_W-1:0]  bias,
  input  logic                     acc_clr,
  input  logic                     last,
  input  logic                     sat_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic                     overflow
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int K_W    = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC, OUT} state_t;

  state_t                    r_state, w_next;
  logic signed [ACC_W:0]     r_mcand;
  logic        [DATA_W-1:0]  r_bsh;
  logic        [K_W-1:0]     r_k;
  logic signed [ACC_W:0]     r_prod;
  logic signed [ACC_W-1:0]   r_bias;
  logic                      r_clr, r_last, r_sat;
  logic signed [ACC_W-1:0]   r_acc;
  logic                      r_ovf;

  logic                      w_top;
  logic signed [SLICE_W:0]   w_slice;
  logic signed [ACC_W:0]     w_slice_ext;
  logic signed [ACC_W:0]     w_partial;
  logic signed [ACC_W:0]     w_base;
  logic signed [ACC_W:0]     w_sum;
  logic                      w_sum_ovf;
  logic signed [ACC_W-1:0]   w_acc_next;

  // Only the most significant slice of b carries the sign; lower slices are magnitudes.
  assign w_top       = (r_k == K_W'(NSLICE - 1));
  assign w_slice     = {w_top & r_bsh[SLICE_W-1], r_bsh[SLICE_W-1:0]};
  assign w_slice_ext = {{(ACC_W - SLICE_W){w_slice[SLICE_W]}}, w_slice};
  assign w_partial   = r_mcand * w_slice_ext;

  assign w_base     = r_clr ? {r_bias[ACC_W-1], r_bias} : {r_acc[ACC_W-1], r_acc};
  assign w_sum      = w_base + r_prod;
  assign w_sum_ovf  = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_acc_next = (w_sum_ovf && r_sat)
                    ? (w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}})
                    : w_sum[ACC_W-1:0];

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all state updates see pre-edge values.
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = MUL;
      end
      MUL:  if (w_top) w_next = ACC;
      ACC:  w_next = r_last ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_bsh   <= '0;
      r_k     <= '0;
      r_prod  <= '0;
      r_bias  <= '0;
      r_clr   <= 1'b0;
      r_last  <= 1'b0;
      r_sat   <= 1'b0;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_mcand <= {{(ACC_W + 1 - DATA_W){a[DATA_W-1]}}, a};
          r_bsh   <= b;
          r_k     <= '0;
          r_prod  <= '0;
          r_bias  <= bias;
          r_clr   <= acc_clr;
          r_last  <= last;
          r_sat   <= sat_en;
        end
        MUL: begin
          r_prod  <= r_prod + w_partial;
          r_mcand <= r_mcand <<< SLICE_W;
          r_bsh   <= r_bsh >> SLICE_W;
          r_k     <= r_k + K_W'(1);
        end
        ACC: begin
          r_acc <= w_acc_next;
          // Overflow is sticky across a chain and only a clean acc_clr beat clears it.
          if (w_sum_ovf)  r_ovf <= 1'b1;
          else if (r_clr) r_ovf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign out_data = r_acc;
  assign overflow = r_ovf;

endmodule
